// File: rtl/des_block_loader.sv
// des_block_loader
// Gathers narrow plaintext/ciphertext beats into one 64-bit block in DES bit
// order (bit 1 = MSB = first bit received). The block is then presented on a
// valid/ready interface that feeds the IP permutation. The loader has one
// assembly register and one output holding register, so the next block can be
// gathered while the current one is stalled downstream.
// Internally the blocks are held as [63:0] vectors. Assigning a [63:0] vector
// to a [1:64] port maps internal bit 63 onto DES bit 1, so the ordering is
// preserved.

module des_block_loader #(
  parameter int IN_WIDTH = 8,
  localparam int BEATS = 64 / IN_WIDTH,
  localparam int CNT_W = $clog2(BEATS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:IN_WIDTH] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             clear_i,
  output logic [1:64]      block_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] beat_cnt_o
);

  logic [IN_WIDTH-1:0] beatBits;
  logic [63:0]         asmBlock_q;
  logic [63:0]         asmBlock_d;
  logic [63:0]         mergedBlock;
  logic [63:0]         outBlock_q;
  logic                outValid_q;
  logic [CNT_W-1:0]    beatCnt_q;
  logic [CNT_W-1:0]    beatCnt_d;
  logic                lastBeat;
  logic                slotFree;
  logic                accept;
  logic                finalAccept;

  assign beatBits = data_i;

  // The next beat is the final one of the block, so accepting it also needs
  // a free output slot. A slot that drains in the same cycle counts as free.
  // clear_i suppresses acceptance, so a beat presented with it is dropped.
  assign lastBeat    = (beatCnt_q == CNT_W'(BEATS - 1));
  assign slotFree    = ~outValid_q | ready_i;
  assign ready_o     = ~lastBeat | slotFree;
  assign accept      = valid_i & ready_o & ~clear_i;
  assign finalAccept = accept & lastBeat;

  // Place the incoming beat into its slot: beat k fills DES bits
  // k*IN_WIDTH+1 .. (k+1)*IN_WIDTH, so beat 0 lands in the MSBs.
  always_comb begin
    mergedBlock = asmBlock_q;
    for (int k = 0; k < BEATS; k++) begin
      if (beatCnt_q == CNT_W'(k)) begin
        mergedBlock[63 - k*IN_WIDTH -: IN_WIDTH] = beatBits;
      end
    end
  end

  // Next assembly state. clear_i wipes the partial block. A final beat hands
  // the block off and restarts assembly from an empty register.
  always_comb begin
    beatCnt_d  = beatCnt_q;
    asmBlock_d = asmBlock_q;
    if (clear_i) begin
      beatCnt_d  = '0;
      asmBlock_d = '0;
    end else if (finalAccept) begin
      beatCnt_d  = '0;
      asmBlock_d = '0;
    end else if (accept) begin
      beatCnt_d  = beatCnt_q + CNT_W'(1);
      asmBlock_d = mergedBlock;
    end
  end

  // Assembly register and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asmBlock_q <= '0;
      beatCnt_q  <= '0;
    end else begin
      asmBlock_q <= asmBlock_d;
      beatCnt_q  <= beatCnt_d;
    end
  end

  // Output holding register. A newly completed block takes priority over
  // emptying the slot, which keeps valid high across a same-cycle drain and
  // reload. Otherwise the data stays frozen while it waits for ready_i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outBlock_q <= '0;
      outValid_q <= 1'b0;
    end else if (finalAccept) begin
      outBlock_q <= mergedBlock;
      outValid_q <= 1'b1;
    end else if (outValid_q && ready_i) begin
      outValid_q <= 1'b0;
    end
  end

  assign block_o    = outBlock_q;
  assign valid_o    = outValid_q;
  assign beat_cnt_o = beatCnt_q;

endmodule

// File: tb/tb_des_block_loader.sv
// tb_des_block_loader
// The bench drives byte-wide, 32-bit and 64-bit loader instances. It runs a
// vector table, a set of hand-written corner sequences, and a randomized
// stream. The random stream is compared against a queue-based model of the
// beats the loader has accepted.

module tb_des_block_loader;

  logic        clk;
  logic        rst;

  logic [7:0]  data8;
  logic        valid8i;
  logic        ready8o;
  logic        clear8;
  logic [63:0] block8;
  logic        valid8o;
  logic        ready8i;
  logic [3:0]  cnt8;

  logic [31:0] data32;
  logic        valid32i;
  logic        ready32o;
  logic        clear32;
  logic [63:0] block32;
  logic        valid32o;
  logic        ready32i;
  logic [1:0]  cnt32;

  logic [63:0] data64;
  logic        valid64i;
  logic        ready64o;
  logic        clear64;
  logic [63:0] block64;
  logic        valid64o;
  logic        ready64i;
  logic [0:0]  cnt64;

  int checks = 0;
  int failures = 0;

  logic        smpReady;
  logic        smpValid;
  logic [3:0]  smpCnt;
  logic [63:0] smpBlock;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        r;
    logic        c;
    logic        expReady;
    logic        expValid;
    logic [3:0]  expCnt;
    logic [63:0] expBlock;
  } vec_t;

  vec_t vecs[$];

  int          pendCnt;
  logic [63:0] pendBlock;
  logic [63:0] expQ[$];
  int          dutBlocksSeen;

  des_block_loader #(.IN_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .data_i(data8), .valid_i(valid8i), .ready_o(ready8o),
    .clear_i(clear8), .block_o(block8), .valid_o(valid8o), .ready_i(ready8i),
    .beat_cnt_o(cnt8)
  );

  des_block_loader #(.IN_WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .data_i(data32), .valid_i(valid32i), .ready_o(ready32o),
    .clear_i(clear32), .block_o(block32), .valid_o(valid32o), .ready_i(ready32i),
    .beat_cnt_o(cnt32)
  );

  des_block_loader #(.IN_WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .data_i(data64), .valid_i(valid64i), .ready_o(ready64o),
    .clear_i(clear64), .block_o(block64), .valid_o(valid64o), .ready_i(ready64i),
    .beat_cnt_o(cnt64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive the byte-wide loader for one cycle and sample its outputs before the edge
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r, input logic c);
    @(negedge clk);
    valid8i = v;
    data8   = d;
    ready8i = r;
    clear8  = c;
    #1;
    smpReady = ready8o;
    smpValid = valid8o;
    smpCnt   = cnt8;
    smpBlock = block8;
  endtask

  function automatic void addVec(input logic v, input logic [7:0] d, input logic r, input logic c,
                                 input logic er, input logic ev, input logic [3:0] ec,
                                 input logic [63:0] eb);
    vec_t x;
    x.v = v; x.d = d; x.r = r; x.c = c;
    x.expReady = er; x.expValid = ev; x.expCnt = ec; x.expBlock = eb;
    vecs.push_back(x);
  endfunction

  function automatic logic [7:0] byteOf(input logic [63:0] b, input int i);
    return b[63 - 8*i -: 8];
  endfunction

  // One cycle of the random stream: compare with the model, then advance the model
  task automatic randCycle(input logic v, input logic [7:0] d, input logic r, input logic c);
    logic expReady;
    applyStimulus(v, d, r, c);
    expReady = (pendCnt < 7) || (expQ.size() == 0) || r;
    checkOutput("rnd_ready", 64'(smpReady), 64'(expReady));
    checkOutput("rnd_valid", 64'(smpValid), 64'(expQ.size() != 0));
    checkOutput("rnd_cnt", 64'(smpCnt), 64'(pendCnt));
    if (expQ.size() != 0) begin
      checkOutput("rnd_block", smpBlock, expQ[0]);
    end
    if (smpValid && r) dutBlocksSeen++;
    if (expQ.size() != 0 && r) void'(expQ.pop_front());
    if (c) begin
      pendCnt   = 0;
      pendBlock = '0;
    end else if (v && expReady) begin
      pendBlock = (pendBlock << 8) | 64'(d);
      pendCnt++;
      if (pendCnt == 8) begin
        expQ.push_back(pendBlock);
        pendCnt   = 0;
        pendBlock = '0;
      end
    end
  endtask

  initial begin
    logic [63:0] blkA;
    logic [63:0] blkB;
    logic [63:0] blkC;
    logic [63:0] blkD;
    blkA = 64'h0123456789ABCDEF;
    blkB = 64'hFEDCBA9876543210;
    blkC = 64'h0F1E2D3C4B5A6978;
    blkD = 64'h8899AABBCCDDEEFF;

    rst = 1'b1;
    data8 = '0;  valid8i = 0;  clear8 = 0;  ready8i = 0;
    data32 = '0; valid32i = 0; clear32 = 0; ready32i = 0;
    data64 = '0; valid64i = 0; clear64 = 0; ready64i = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_ready", 64'(ready8o), 64'd1);
    checkOutput("rst_valid", 64'(valid8o), 64'd0);
    checkOutput("rst_cnt", 64'(cnt8), 64'd0);
    checkOutput("rst_block", block8, 64'd0);

    for (int i = 0; i < 8; i++) addVec(1, byteOf(blkA, i), 1, 0, 1, 0, 4'(i), '0);
    addVec(0, 8'h00, 0, 0, 1, 1, 0, blkA);
    addVec(0, 8'h00, 1, 0, 1, 1, 0, blkA);
    addVec(1, 8'hAA, 1, 0, 1, 0, 0, '0);
    addVec(1, 8'hBB, 1, 0, 1, 0, 1, '0);
    addVec(1, 8'hCC, 1, 0, 1, 0, 2, '0);
    addVec(1, 8'hDD, 1, 1, 1, 0, 3, '0);
    for (int i = 0; i < 8; i++) addVec(1, 8'(8'h11 * (i + 1)), 1, 0, 1, 0, 4'(i), '0);
    addVec(0, 8'h00, 0, 0, 1, 1, 0, 64'h1122334455667788);
    addVec(0, 8'h00, 1, 0, 1, 1, 0, 64'h1122334455667788);
    addVec(0, 8'h00, 0, 0, 1, 0, 0, '0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].c);
      checkOutput($sformatf("vec%0d_ready", i), 64'(smpReady), 64'(vecs[i].expReady));
      checkOutput($sformatf("vec%0d_valid", i), 64'(smpValid), 64'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d_cnt", i), 64'(smpCnt), 64'(vecs[i].expCnt));
      if (vecs[i].expValid) checkOutput($sformatf("vec%0d_block", i), smpBlock, vecs[i].expBlock);
    end

    // Back-to-back blocks with the output stalled
    for (int i = 0; i < 8; i++) applyStimulus(1, byteOf(blkA, i), 0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(1, byteOf(blkB, i), 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 8'h10, 0, 0);
      checkOutput("stall_ready", 64'(smpReady), 64'd0);
      checkOutput("stall_cnt", 64'(smpCnt), 64'd7);
      checkOutput("stall_valid", 64'(smpValid), 64'd1);
      checkOutput("stall_block", smpBlock, blkA);
    end
    applyStimulus(1, 8'h10, 1, 0);
    checkOutput("drain_ready", 64'(smpReady), 64'd1);
    checkOutput("drain_block", smpBlock, blkA);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("b2b_valid", 64'(smpValid), 64'd1);
    checkOutput("b2b_block", smpBlock, blkB);
    checkOutput("b2b_cnt", 64'(smpCnt), 64'd0);
    applyStimulus(0, 8'h00, 1, 0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("b2b_empty", 64'(smpValid), 64'd0);

    // Asynchronous reset while a block is stalled and another is half-built
    for (int i = 0; i < 8; i++) applyStimulus(1, byteOf(blkC, i), 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, byteOf(blkA, i), 0, 0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("pre_arst_cnt", 64'(smpCnt), 64'd5);
    checkOutput("pre_arst_block", smpBlock, blkC);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_valid", 64'(valid8o), 64'd0);
    checkOutput("arst_block", block8, 64'd0);
    checkOutput("arst_cnt", 64'(cnt8), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(1, byteOf(blkD, i), 1, 0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("post_arst_valid", 64'(smpValid), 64'd1);
    checkOutput("post_arst_block", smpBlock, blkD);

    // 32-bit beats
    @(negedge clk);
    valid32i = 1; data32 = 32'h01234567; ready32i = 1;
    #1;
    checkOutput("w32_ready", 64'(ready32o), 64'd1);
    @(negedge clk);
    data32 = 32'h89ABCDEF;
    #1;
    checkOutput("w32_cnt", 64'(cnt32), 64'd1);
    checkOutput("w32_valid_early", 64'(valid32o), 64'd0);
    @(negedge clk);
    valid32i = 0;
    #1;
    checkOutput("w32_valid", 64'(valid32o), 64'd1);
    checkOutput("w32_block", block32, blkA);

    // 64-bit beats: ready_o follows slot availability
    @(negedge clk);
    valid64i = 1; data64 = blkA; ready64i = 0;
    #1;
    checkOutput("w64_ready_idle", 64'(ready64o), 64'd1);
    @(negedge clk);
    data64 = blkB;
    #1;
    checkOutput("w64_valid", 64'(valid64o), 64'd1);
    checkOutput("w64_block", block64, blkA);
    checkOutput("w64_ready_full", 64'(ready64o), 64'd0);
    @(negedge clk);
    ready64i = 1;
    #1;
    checkOutput("w64_ready_pass", 64'(ready64o), 64'd1);
    @(negedge clk);
    valid64i = 0;
    #1;
    checkOutput("w64_reload_valid", 64'(valid64o), 64'd1);
    checkOutput("w64_reload_block", block64, blkB);
    @(negedge clk);
    #1;
    checkOutput("w64_drained", 64'(valid64o), 64'd0);

    // Drain the byte loader so that it matches an empty model
    applyStimulus(0, 8'h00, 1, 1);
    applyStimulus(0, 8'h00, 1, 0);
    pendCnt = 0;
    pendBlock = '0;
    expQ.delete();
    dutBlocksSeen = 0;

    // Continuous stream of 100 blocks with ready_i held high
    for (int i = 0; i < 800; i++) randCycle(1, 8'($urandom), 1, 0);
    randCycle(0, 8'h00, 1, 0);
    randCycle(0, 8'h00, 1, 0);
    checkOutput("stream_blocks", 64'(dutBlocksSeen), 64'd100);

    // Random valid, ready and clear traffic
    for (int i = 0; i < 1500; i++) begin
      randCycle(($urandom_range(3) != 0), 8'($urandom), 1'($urandom_range(1)),
                ($urandom_range(31) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
